// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku cursor/command path.
// Optional build macro CURSOR_WRAP_EN selects wrap-around cursor movement in sudoku_cursor_fsm.
package sudoku_pkg;

    localparam int GRID_SIZE    = 9;
    localparam int NUM_BTNS     = 12;
    localparam int NUM_ACT_BTNS = 8;

    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LEFT    = 2;
    localparam int BTN_RIGHT   = 3;
    localparam int BTN_CONFIRM = 4;
    localparam int BTN_CANCEL  = 5;
    localparam int BTN_ERASE   = 6;
    localparam int BTN_START   = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NAV   = 2'd1,
        S_DIGIT = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Action code is button index + 1, so the encoder can convert directly.
    typedef enum logic [3:0] {
        ACT_NONE    = 4'd0,
        ACT_UP      = 4'd1,
        ACT_DOWN    = 4'd2,
        ACT_LEFT    = 4'd3,
        ACT_RIGHT   = 4'd4,
        ACT_CONFIRM = 4'd5,
        ACT_CANCEL  = 4'd6,
        ACT_ERASE   = 4'd7,
        ACT_START   = 4'd8
    } action_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] digit;
    } wr_req_t;

endpackage

// File: rtl/sudoku_btn_action_enc.sv
// Collapses the 12-bit debounced pulse vector into one action; lowest set index of 0..7 wins.
module sudoku_btn_action_enc
    import sudoku_pkg::*;
(
    input  logic [NUM_BTNS-1:0] btn_pulse,
    output action_t             act
);

    // Buttons 8..11 have no function in this block.
    logic unused_btns;
    assign unused_btns = ^btn_pulse[NUM_BTNS-1:NUM_ACT_BTNS];

    always_comb begin
        act = ACT_NONE;
        for (int i = NUM_ACT_BTNS - 1; i >= 0; i--) begin
            if (btn_pulse[i]) act = action_t'(4'(i + 1));
        end
    end

endmodule

// File: rtl/sudoku_cursor_fsm.sv
// Sudoku command FSM: cursor movement, digit entry and board-store write handshake.
// Build macro CURSOR_WRAP_EN: cursor wraps at grid edges instead of saturating.
module sudoku_cursor_fsm
    import sudoku_pkg::*;
#(
    parameter int GRID_SIZE  = sudoku_pkg::GRID_SIZE,
    parameter int WR_TIMEOUT = 16,
    parameter int TMO_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] btn_pulse,
    input  logic        cell_fixed,
    input  logic        wr_ready,
    output logic        wr_valid,
    output logic [3:0]  cursor_row,
    output logic [3:0]  cursor_col,
    output logic [3:0]  digit,
    output logic        block_controller,
    output logic        wr_error,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0]       MAX_POS  = 4'(GRID_SIZE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);

    state_t           state;
    action_t          act;
    logic [TMO_W-1:0] tmo_cnt;

    sudoku_btn_action_enc u_enc (
        .btn_pulse (btn_pulse),
        .act       (act)
    );

    function automatic logic [3:0] pos_dec(input logic [3:0] p);
`ifdef CURSOR_WRAP_EN
        return (p == 4'd0) ? MAX_POS : p - 4'd1;
`else
        return (p == 4'd0) ? 4'd0 : p - 4'd1;
`endif
    endfunction

    function automatic logic [3:0] pos_inc(input logic [3:0] p);
`ifdef CURSOR_WRAP_EN
        return (p >= MAX_POS) ? 4'd0 : p + 4'd1;
`else
        return (p >= MAX_POS) ? MAX_POS : p + 4'd1;
`endif
    endfunction

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cursor_row       <= 4'd0;
            cursor_col       <= 4'd0;
            digit            <= 4'd0;
            wr_valid         <= 1'b0;
            block_controller <= 1'b0;
            wr_error         <= 1'b0;
            tmo_cnt          <= '0;
        end else begin
            wr_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (act == ACT_START) begin
                        state      <= S_NAV;
                        cursor_row <= 4'd0;
                        cursor_col <= 4'd0;
                        digit      <= 4'd0;
                    end
                end
                S_NAV: begin
                    case (act)
                        ACT_UP:    cursor_row <= pos_dec(cursor_row);
                        ACT_DOWN:  cursor_row <= pos_inc(cursor_row);
                        ACT_LEFT:  cursor_col <= pos_dec(cursor_col);
                        ACT_RIGHT: cursor_col <= pos_inc(cursor_col);
                        ACT_CONFIRM: begin
                            if (!cell_fixed) begin
                                state <= S_DIGIT;
                                digit <= 4'd1;
                            end
                        end
                        ACT_ERASE: begin
                            if (!cell_fixed) begin
                                state            <= S_WRITE;
                                digit            <= 4'd0;
                                wr_valid         <= 1'b1;
                                block_controller <= 1'b1;
                                tmo_cnt          <= '0;
                            end
                        end
                        ACT_START: state <= S_IDLE;
                        default: ;
                    endcase
                end
                S_DIGIT: begin
                    case (act)
                        ACT_UP:   digit <= (digit >= 4'd9) ? 4'd1 : digit + 4'd1;
                        ACT_DOWN: digit <= (digit <= 4'd1) ? 4'd9 : digit - 4'd1;
                        ACT_CONFIRM: begin
                            state            <= S_WRITE;
                            wr_valid         <= 1'b1;
                            block_controller <= 1'b1;
                            tmo_cnt          <= '0;
                        end
                        ACT_CANCEL: begin
                            state <= S_NAV;
                            digit <= 4'd0;
                        end
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    // Handshake is tested first so a ready on the last timeout cycle still lands.
                    if (wr_ready) begin
                        state            <= S_NAV;
                        wr_valid         <= 1'b0;
                        block_controller <= 1'b0;
                        digit            <= 4'd0;
                        tmo_cnt          <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state            <= S_NAV;
                        wr_valid         <= 1'b0;
                        block_controller <= 1'b0;
                        digit            <= 4'd0;
                        wr_error         <= 1'b1;
                        tmo_cnt          <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sudoku_cursor_fsm.md
Name: sudoku_cursor_fsm

Overview:
- Consumes the 12 one-cycle debounced button pulses from the controller stage.
- Turns them into Sudoku game commands:
  - cursor movement on the 9x9 grid;
  - digit selection;
  - cell write/erase requests to the board store over a valid/ready handshake.
- Drives block_controller back upstream, so button input is frozen while a write is outstanding.

Parameters:
- GRID_SIZE, 9, cells per row/column; cursor range 0..GRID_SIZE-1.
- WR_TIMEOUT, 16, cycles to wait for wr_ready before abandoning a write.
- TMO_W, 5, width of timeout counter; must hold WR_TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_pulse  in  12  one-cycle button pulses from the controller (controller_output).
- cell_fixed  in  1  current cursor cell is a given clue; combinational from the board store, valid every cycle.
- wr_ready  in  1  board store accepts the write.
- wr_valid  out  1  write request; row/col/digit are stable while high.
- cursor_row  out  4  cursor row, 0..8.
- cursor_col  out  4  cursor column, 0..8.
- digit  out  4  digit value; 1..9 entry, 0 = erase.
- block_controller  out  1  high while in S_WRITE; freezes upstream debouncers.
- wr_error  out  1  one-cycle pulse on write timeout.
- state_dbg  out  2  current FSM state encoding.

Behaviour:
- Button map (index): 0 up, 1 down, 2 left, 3 right, 4 confirm, 5 cancel, 6 erase, 7 start; 8..11 ignored.
- Simultaneous pulses: only the lowest set index among 0..7 acts; all others in that cycle are dropped.
- All outputs are registered. A pulse in cycle n is reflected in the outputs at cycle n+1.
- Reset (asynchronous, active-low): state S_IDLE, cursor (0,0), digit 0, wr_valid 0, block_controller 0, wr_error 0, timeout counter 0. Outputs take these values immediately, including mid-write.
- States: S_IDLE=0, S_NAV=1, S_DIGIT=2, S_WRITE=3.
- S_IDLE:
  - start -> S_NAV, cursor (0,0), digit 0.
  - All other buttons ignored.
- S_NAV:
  - up/down change row by -1/+1; left/right change column by -1/+1.
  - At a grid edge the cursor saturates (0 or GRID_SIZE-1).
  - confirm: if cell_fixed, no action; else -> S_DIGIT with digit=1.
  - erase: if cell_fixed, no action; else digit=0 -> S_WRITE.
  - start -> S_IDLE; cursor is retained.
  - cancel ignored.
- S_DIGIT:
  - up increments digit, 9 wraps to 1; down decrements, 1 wraps to 9.
  - confirm -> S_WRITE.
  - cancel -> S_NAV; digit reset to 0.
  - left, right, erase, start ignored.
- S_WRITE:
  - wr_valid=1 and block_controller=1 from the first cycle in the state.
  - cursor and digit are held stable; all btn_pulse inputs are ignored.
  - Handshake completes in the cycle where wr_valid and wr_ready are both high. Next cycle: -> S_NAV, wr_valid=0, block_controller=0, digit=0.
  - Timeout counter increments every cycle in S_WRITE while wr_ready is low.
  - When the counter reaches WR_TIMEOUT without a handshake: -> S_NAV, wr_error=1 for exactly one cycle, counter cleared.
  - wr_ready arriving in the same cycle as the timeout: the handshake wins and wr_error stays 0.
- wr_ready is don't-care outside S_WRITE.
- cell_fixed is sampled only on confirm/erase in S_NAV.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: cursor movement wraps around the grid (row 0 up -> 8, col 8 right -> 0, and likewise for the other edges).
- Undefined: cursor saturates at the grid edges, as in the baseline above.
- Digit wrap in S_DIGIT is unconditional and is not affected by the macro.

Decomposition:
- Shared package sudoku_pkg:
  - GRID_SIZE constant;
  - state enum typedef (S_IDLE, S_NAV, S_DIGIT, S_WRITE);
  - button-index constants BTN_UP..BTN_START;
  - action typedef (ACT_NONE, ACT_UP, ..., ACT_START).
- One sub-module, sudoku_btn_action_enc: combinational 12-bit pulse vector -> single action code, lowest-index priority.

Test Plan:
- Reset, then start pulse (bit 7) -> state_dbg 1, cursor (0,0). Then 3x right, 2x down -> cursor_row 2, cursor_col 3.
- At (0,0), pulse up and left -> cursor stays (0,0). With CURSOR_WRAP_EN defined -> cursor (8,8).
- At (4,4), cell_fixed=0: confirm, 3x up, confirm -> wr_valid=1, digit 4, block_controller=1. Hold wr_ready low 3 cycles, then high 1 cycle -> next cycle wr_valid 0, state_dbg 1.
- In S_DIGIT at digit 9: pulse up -> digit 1. Pulse down -> digit 9. Pulse cancel -> state_dbg 1, digit 0.
- bits 0 and 3 pulsed in the same cycle -> only the up move happens. With cell_fixed=1, confirm -> state unchanged.
- Enter S_WRITE with wr_ready held low -> after 16 cycles, wr_error pulses for 1 cycle and state returns to S_NAV. Repeat, asserting reset mid-write -> wr_valid drops immediately and state_dbg 0.
